spi_dac_responder: RTL and testbench
====================================

Name: spi_dac_responder

Overview:
- SPI responder for the serial DAC link: it plays the DAC side of the frames the SPI DAC initiator sends.
- Samples CS/SCK/SDI/LD from the 4-wire DAC bus in the system clock domain and deserialises 16-bit write frames.
- Latches the frames into an input register and moves them to an output register on an LD pulse.
- Used as a loopback checker and on-chip DAC model, so processed samples can be observed digitally without the external converter.

Parameters:
- FRAME_BITS, 16, bits per write frame (MSB first).
- DATA_W, 10, width of the sample field.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous bus input (minimum 2).

Ports:
- sysclk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- dac_cs  input  1  chip select, active low.
- dac_sck  input  1  serial clock; data sampled on the rising edge.
- dac_sdi  input  1  serial data, MSB first.
- dac_ld  input  1  load strobe, active low; its falling edge transfers the input register.
- dac_value  output  DATA_W  current converter output code.
- cfg_buf  output  1  latched BUF bit.
- cfg_ga_n  output  1  latched gain-select bit (1 = 1x).
- cfg_shdn_n  output  1  latched shutdown bit (0 = output off).
- frame_done  output  1  one-cycle pulse: valid frame captured into the input register.
- frame_err  output  1  one-cycle pulse: frame discarded.
- dac_update  output  1  one-cycle pulse: output register reloaded.

Behaviour:
- Reset (asynchronous, rst_n low):
  - dac_value=0, cfg_buf=0, cfg_ga_n=1, cfg_shdn_n=0.
  - All pulse outputs 0; input register cleared to 0; FSM to IDLE.
  - Synchronisers reset to the idle bus levels: cs=1, sck=0, ld=1.
- Synchronisation and edge detection:
  - Each bus input passes through SYNC_STAGES flip-flops.
  - Edges are detected on the synchronised signals only.
  - The bus must hold SCK high and low for at least 4 sysclk each; faster buses are unsupported.
- Frame layout, bit 15 first:
  - [15] channel, must be 0.
  - [14] BUF.
  - [13] GA_n.
  - [12] SHDN_n.
  - [11:2] sample.
  - [1:0] don't care.
- FSM states: IDLE, SHIFT, OVER.
  - IDLE: synced-CS falling edge -> SHIFT; bit counter cleared, shift register cleared.
  - SHIFT: on each synced-SCK rising edge, shift = {shift[14:0], sdi_sync}, counter +1. Counter reaching 17 -> OVER.
  - OVER: further SCK edges are ignored.
  - Any state: synced-CS rising edge -> IDLE, evaluated the same cycle.
- CS rising-edge evaluation:
  - Counter==16 and bit15==0: copy the word into the input register and pulse frame_done the next cycle.
  - Counter!=16 (including OVER), or bit15==1: input register unchanged; pulse frame_err the next cycle.
  - A CS rising edge while in IDLE (no falling edge seen) produces no pulse.
- Load:
  - On a synced-LD falling edge, in the next cycle: dac_value, cfg_buf, cfg_ga_n and cfg_shdn_n load from the input register, and dac_update pulses.
  - LD is honoured in any FSM state, including mid-frame; the last completed frame is used.
- Simultaneous events: a CS rising edge with a valid frame and an LD falling edge in the same cycle means the new frame is forwarded straight to the outputs, and frame_done and dac_update pulse together.
- SCK edge coinciding with the CS falling edge: ignored; counting starts after CS is seen low.
- Reset mid-frame: the partial frame is lost; outputs return to their reset values immediately.
- Latency: a bus pin edge acts SYNC_STAGES+1 sysclk after it occurs; pulses appear one cycle after that.

Test Plan:
- Reset check: hold rst_n low, then release -> dac_value=0, cfg_shdn_n=0, cfg_ga_n=1, no pulses.
- Valid write and load: frame 16'h3A94, then an LD low pulse -> frame_done once; then dac_value=10'h2A5, cfg_buf=0, cfg_ga_n=1, cfg_shdn_n=1, dac_update once.
- Short frame: send 12 bits and raise CS -> frame_err once; a following LD keeps the previous dac_value (10'h2A5).
- Long frame and wrong channel:
  - 20 SCK edges -> frame_err, input register unchanged.
  - Frame 16'hB000 -> frame_err, no output change.
- Simultaneous events: CS rise of frame 16'h3004 in the same synced cycle as an LD fall -> dac_value=10'h001, with frame_done and dac_update in the same cycle.
- Reset mid-frame: assert rst_n after 8 bits of 16'h3FFC -> outputs at reset values. A subsequent full 16'h3FFC frame plus LD -> dac_value=10'h3FF.

Source files
------------

// File: rtl/spi_dac_responder.sv
// DAC-side responder for the 4-wire serial DAC link: synchronises the bus,
// deserialises write frames, and models the converter's input/output registers.
module spi_dac_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              dac_cs,
  input  logic              dac_sck,
  input  logic              dac_sdi,
  input  logic              dac_ld,
  output logic [DATA_W-1:0] dac_value,
  output logic              cfg_buf,
  output logic              cfg_ga_n,
  output logic              cfg_shdn_n,
  output logic              frame_done,
  output logic              frame_err,
  output logic              dac_update
);

  // state    | meaning
  // ST_IDLE  | CS high, waiting for a frame to start
  // ST_SHIFT | CS low, shifting bits in on synced SCK rising edges
  // ST_OVER  | more than FRAME_BITS clocks seen; frame will be rejected
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam int BIT_CH     = FRAME_BITS - 1;
  localparam int BIT_BUF    = FRAME_BITS - 2;
  localparam int BIT_GA     = FRAME_BITS - 3;
  localparam int BIT_SHDN   = FRAME_BITS - 4;
  localparam int BIT_SMP_HI = FRAME_BITS - 5;

  // Bus synchronisers; reset to idle bus levels so release of reset is edge-free.
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] ld_sync_q, ld_sync_d;

  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], dac_cs};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], dac_sck};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], dac_sdi};
    ld_sync_d  = {ld_sync_q[SYNC_STAGES-2:0], dac_ld};
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      ld_sync_q  <= '1;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      ld_sync_q  <= ld_sync_d;
    end
  end

  logic cs_s, sck_s, sdi_s, ld_s;
  logic cs_prev_q, sck_prev_q, ld_prev_q;
  logic cs_prev_d, sck_prev_d, ld_prev_d;
  logic cs_rise, cs_fall, sck_rise, ld_fall;

  always_comb begin
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    sdi_s      = sdi_sync_q[SYNC_STAGES-1];
    ld_s       = ld_sync_q[SYNC_STAGES-1];
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
    ld_prev_d  = ld_s;
    cs_rise    = cs_s & ~cs_prev_q;
    cs_fall    = ~cs_s & cs_prev_q;
    sck_rise   = sck_s & ~sck_prev_q;
    ld_fall    = ~ld_s & ld_prev_q;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      ld_prev_q  <= 1'b1;
    end else begin
      cs_prev_q  <= cs_prev_d;
      sck_prev_q <= sck_prev_d;
      ld_prev_q  <= ld_prev_d;
    end
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;

  logic                    in_buf_q, in_buf_d;
  logic                    in_ga_n_q, in_ga_n_d;
  logic                    in_shdn_n_q, in_shdn_n_d;
  logic [DATA_W-1:0]       in_sample_q, in_sample_d;

  logic                    out_buf_q, out_buf_d;
  logic                    out_ga_n_q, out_ga_n_d;
  logic                    out_shdn_n_q, out_shdn_n_d;
  logic [DATA_W-1:0]       out_value_q, out_value_d;

  logic                    frame_done_q, frame_done_d;
  logic                    frame_err_q, frame_err_d;
  logic                    dac_update_q, dac_update_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q + CNT_ONE;
    shift_d      = shift_q;
    in_buf_d     = in_buf_q;
    in_ga_n_d    = in_ga_n_q;
    in_shdn_n_d  = in_shdn_n_q;
    in_sample_d  = in_sample_q;
    out_buf_d    = out_buf_q;
    out_ga_n_d   = out_ga_n_q;
    out_shdn_n_d = out_shdn_n_q;
    out_value_d  = out_value_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    dac_update_d = 1'b0;

    // CS rising edge closes a frame from any state and wins over SCK that cycle.
    if (cs_rise) begin
      if (state_q != ST_IDLE) begin
        if (state_q == ST_SHIFT && cnt_q == CNT_FULL && !shift_q[BIT_CH]) begin
          in_buf_d     = shift_q[BIT_BUF];
          in_ga_n_d    = shift_q[BIT_GA];
          in_shdn_n_d  = shift_q[BIT_SHDN];
          in_sample_d  = shift_q[BIT_SMP_HI -: DATA_W];
          frame_done_d = 1'b1;
        end else begin
          frame_err_d  = 1'b1;
        end
      end
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
            cnt_d   = cnt_inc;
            if (cnt_inc == CNT_OVER) begin
              state_d = ST_OVER;
            end
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Loading from the _d side forwards a frame that completes in the same cycle.
    if (ld_fall) begin
      out_buf_d    = in_buf_d;
      out_ga_n_d   = in_ga_n_d;
      out_shdn_n_d = in_shdn_n_d;
      out_value_d  = in_sample_d;
      dac_update_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      in_buf_q     <= 1'b0;
      in_ga_n_q    <= 1'b0;
      in_shdn_n_q  <= 1'b0;
      in_sample_q  <= '0;
      out_buf_q    <= 1'b0;
      out_ga_n_q   <= 1'b1;
      out_shdn_n_q <= 1'b0;
      out_value_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      dac_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      in_buf_q     <= in_buf_d;
      in_ga_n_q    <= in_ga_n_d;
      in_shdn_n_q  <= in_shdn_n_d;
      in_sample_q  <= in_sample_d;
      out_buf_q    <= out_buf_d;
      out_ga_n_q   <= out_ga_n_d;
      out_shdn_n_q <= out_shdn_n_d;
      out_value_q  <= out_value_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      dac_update_q <= dac_update_d;
    end
  end

  assign dac_value  = out_value_q;
  assign cfg_buf    = out_buf_q;
  assign cfg_ga_n   = out_ga_n_q;
  assign cfg_shdn_n = out_shdn_n_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign dac_update = dac_update_q;

endmodule

// File: tb/tb_spi_dac_responder.sv
// Directed bench for spi_dac_responder: drives bus frames and LD strobes,
// checks pulse counts and output register contents against hand-computed values.
module tb_spi_dac_responder;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       dac_cs = 1'b1;
  logic       dac_sck = 1'b0;
  logic       dac_sdi = 1'b0;
  logic       dac_ld = 1'b1;
  logic [9:0] dac_value;
  logic       cfg_buf, cfg_ga_n, cfg_shdn_n;
  logic       frame_done, frame_err, dac_update;

  int n_vec  = 0;
  int n_miss = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_upd  = 0;
  int n_both = 0;
  int b_done, b_err, b_upd, b_both;

  spi_dac_responder dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .dac_cs     (dac_cs),
    .dac_sck    (dac_sck),
    .dac_sdi    (dac_sdi),
    .dac_ld     (dac_ld),
    .dac_value  (dac_value),
    .cfg_buf    (cfg_buf),
    .cfg_ga_n   (cfg_ga_n),
    .cfg_shdn_n (cfg_shdn_n),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dac_update (dac_update)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    #1;
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (dac_update) n_upd++;
    if (frame_done && dac_update) n_both++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    b_done = n_done;
    b_err  = n_err;
    b_upd  = n_upd;
    b_both = n_both;
  endtask

  // Bits past 16 are sent as zero.
  task automatic send_bits(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dac_sdi = (i < 16) ? word[15-i] : 1'b0;
      wait_cyc(6);
      dac_sck = 1'b1;
      wait_cyc(6);
      dac_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    dac_cs = 1'b0;
    wait_cyc(6);
  endtask

  task automatic cs_high();
    wait_cyc(6);
    dac_cs = 1'b1;
    wait_cyc(8);
  endtask

  task automatic frame(input logic [15:0] word, input int nbits);
    cs_low();
    send_bits(word, nbits);
    cs_high();
  endtask

  task automatic ld_pulse();
    dac_ld = 1'b0;
    wait_cyc(6);
    dac_ld = 1'b1;
    wait_cyc(6);
  endtask

  initial begin
    wait_cyc(3);
    chk("rst_value_hold", 32'(dac_value), 32'h0);
    chk("rst_shdn_hold", 32'(cfg_shdn_n), 32'h0);
    chk("rst_ga_hold", 32'(cfg_ga_n), 32'h1);
    rst_n = 1'b1;
    wait_cyc(6);
    chk("rst_value", 32'(dac_value), 32'h0);
    chk("rst_buf", 32'(cfg_buf), 32'h0);
    chk("rst_pulses", 32'(n_done + n_err + n_upd), 32'h0);

    mark();
    frame(16'h3A94, 16);
    chk("valid_done", 32'(n_done - b_done), 32'h1);
    chk("valid_no_err", 32'(n_err - b_err), 32'h0);
    chk("valid_no_early_load", 32'(dac_value), 32'h0);
    ld_pulse();
    chk("valid_update", 32'(n_upd - b_upd), 32'h1);
    chk("valid_value", 32'(dac_value), 32'h2A5);
    chk("valid_buf", 32'(cfg_buf), 32'h0);
    chk("valid_ga", 32'(cfg_ga_n), 32'h1);
    chk("valid_shdn", 32'(cfg_shdn_n), 32'h1);

    mark();
    frame(16'h3FFC, 12);
    chk("short_err", 32'(n_err - b_err), 32'h1);
    chk("short_no_done", 32'(n_done - b_done), 32'h0);
    ld_pulse();
    chk("short_update", 32'(n_upd - b_upd), 32'h1);
    chk("short_value", 32'(dac_value), 32'h2A5);

    mark();
    frame(16'h3004, 20);
    chk("long_err", 32'(n_err - b_err), 32'h1);
    chk("long_no_done", 32'(n_done - b_done), 32'h0);
    ld_pulse();
    chk("long_value", 32'(dac_value), 32'h2A5);

    mark();
    frame(16'hB000, 16);
    chk("chan_err", 32'(n_err - b_err), 32'h1);
    chk("chan_no_done", 32'(n_done - b_done), 32'h0);
    chk("chan_value", 32'(dac_value), 32'h2A5);
    ld_pulse();
    chk("chan_value_ld", 32'(dac_value), 32'h2A5);
    chk("chan_shdn_ld", 32'(cfg_shdn_n), 32'h1);

    mark();
    cs_low();
    send_bits(16'h3004, 16);
    wait_cyc(6);
    dac_cs = 1'b1;
    dac_ld = 1'b0;
    wait_cyc(8);
    dac_ld = 1'b1;
    wait_cyc(6);
    chk("simul_both", 32'(n_both - b_both), 32'h1);
    chk("simul_done", 32'(n_done - b_done), 32'h1);
    chk("simul_update", 32'(n_upd - b_upd), 32'h1);
    chk("simul_value", 32'(dac_value), 32'h001);
    chk("simul_ga", 32'(cfg_ga_n), 32'h1);

    cs_low();
    send_bits(16'h3FFC, 8);
    wait_cyc(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_value", 32'(dac_value), 32'h0);
    chk("midrst_shdn", 32'(cfg_shdn_n), 32'h0);
    chk("midrst_ga", 32'(cfg_ga_n), 32'h1);
    chk("midrst_buf", 32'(cfg_buf), 32'h0);
    dac_cs  = 1'b1;
    dac_sck = 1'b0;
    wait_cyc(4);
    mark();
    rst_n = 1'b1;
    wait_cyc(10);
    chk("midrst_no_pulses", 32'((n_done - b_done) + (n_err - b_err) + (n_upd - b_upd)), 32'h0);

    mark();
    frame(16'h3FFC, 16);
    chk("after_rst_done", 32'(n_done - b_done), 32'h1);
    ld_pulse();
    chk("after_rst_value", 32'(dac_value), 32'h3FF);
    chk("after_rst_shdn", 32'(cfg_shdn_n), 32'h1);
    chk("after_rst_buf", 32'(cfg_buf), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
